uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, next generation of the fixed 8N1 transmitter. Supports:
- configurable data width (5-9 bits)
- none/odd/even parity
- 1 or 2 stop bits
- 16-bit bit-period divider
- optional input FIFO for gap-free back-to-back frames

Sits between the command/response logic and the board TX pin. Uses a ready/valid byte handshake.

Parameters:
CLKS_PER_BIT, 87, clocks per bit period; legal range 1..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
FIFO_DEPTH, 4, FIFO entries; power of 2, at least 2; used only when UART_TX_FIFO_EN is defined.

Ports:
i_Clock  in  1  single system clock; all logic on the rising edge.
i_Rst_L  in  1  asynchronous, active-low reset.
i_Tx_DV  in  1  byte valid; accepted only in a cycle where o_Tx_Ready=1.
i_Tx_Byte  in  DATA_BITS  data to send.
o_Tx_Ready  out  1  block can accept a byte this cycle.
o_Tx_Active  out  1  high from start-bit entry until the final stop bit completes.
o_Tx_Serial  out  1  serial line; idle high; registered output.
o_Tx_Done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (asynchronous, immediate) sets: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, FSM=IDLE, counters=0, FIFO empty.
- A reset asserted mid-frame aborts the frame. The line goes high at once and no Done pulse is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: line high. On acceptance, latch the byte and move to START.
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive bit[idx] for CLKS_PER_BIT cycles, idx 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY!=0, otherwise to STOP.
- PARITY: odd mode drives ~^data; even mode drives ^data. Held CLKS_PER_BIT cycles.
- STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
- Latency: byte accepted at edge N, start bit visible on o_Tx_Serial from edge N+1.
- Frame length F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- End of frame: on the final stop cycle, o_Tx_Done=1 is registered for exactly one cycle, and o_Tx_Active falls on the same edge.
- Bit counter width is clog2(CLKS_PER_BIT+1), at least 1. Compare against CLKS_PER_BIT-1. CLKS_PER_BIT=1 must give single-cycle bits.
- Without FIFO:
  - o_Tx_Ready = (FSM==IDLE).
  - i_Tx_DV while not ready is ignored; the in-flight byte is unaffected.
  - Minimum inter-frame gap is 1 idle-high cycle.
- Undefined FSM encodings recover to IDLE with the line high.

Optional Feature:
UART_TX_FIFO_EN.
Defined:
- Input FIFO of FIFO_DEPTH entries; o_Tx_Ready = !full.
- Push on i_Tx_DV & o_Tx_Ready.
- Pop when IDLE and not empty, or on the final stop cycle when not empty. In the second case START begins the next cycle with no idle gap; o_Tx_Done still pulses and o_Tx_Active stays high.
- Simultaneous push and pop when full is impossible, since ready=0. Simultaneous push and pop otherwise leaves the count unchanged.
- A push into an empty FIFO while IDLE reaches the line 2 cycles after acceptance.

Undefined: no FIFO; behaviour is as listed above with 1-cycle acceptance latency.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; send 0xA5 -> line holds 0,1,0,1,0,0,1,0,1,0,1, each for 4 cycles. Done pulses once, 44 cycles after the start bit appears; Active high for exactly those 44 cycles.
- Same configuration with PARITY=1, send 0xA5 -> parity bit = 1. With PARITY=0 -> 10-bit frame, no parity slot.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=1; send 0x41 -> line 0,1,0,0,0,0,0,1,1,1, then idle high. Frame is 10 cycles.
- No FIFO: pulse i_Tx_DV with 0x3C during a frame -> ignored, Ready=0, original frame intact, only one Done pulse.
- FIFO enabled, depth 4: push 0x11, 0x22, 0x33 in consecutive cycles -> three frames with no idle cycles between them. Active stays high throughout; three Done pulses; Ready stays 1.
- Assert i_Rst_L=0 during data bit 3 -> line goes to 1 asynchronously, Active=0, no Done pulse. After release, the next byte transmits correctly.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stop bits)
// optional input FIFO for back-to-back frames when UART_TX_FIFO_EN is defined
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] sh;
  logic par;
  logic bit_end;
  logic last_stop;
  logic start;
  logic [DATA_BITS-1:0] start_byte;
  assign bit_end   = cnt == CMAX;
  assign last_stop = state == S_STOP && bit_end && idx == 4'(STOP_BITS - 1);
`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fill;
  logic push;
  assign o_Tx_Ready = fill != (AW+1)'(FIFO_DEPTH);
  assign push       = i_Tx_DV && o_Tx_Ready;
  assign start      = fill != '0 && (state == S_IDLE || last_stop);
  assign start_byte = mem[rp];
  always_ff @(posedge i_Clock)
    if (push) mem[wp] <= i_Tx_Byte;
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (start) rp <= rp + 1'b1;
      fill <= (push && !start) ? fill + 1'b1 : (!push && start) ? fill - 1'b1 : fill;
    end
`else
  assign o_Tx_Ready = state == S_IDLE;
  assign start      = i_Tx_DV && state == S_IDLE;
  assign start_byte = i_Tx_Byte;
`endif
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      par         <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          cnt         <= '0;
          idx         <= '0;
          if (start) begin
            sh          <= start_byte;
            par         <= (PARITY == 1) ? ~^start_byte : ^start_byte;
            state       <= S_START;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
          end
        end
        S_START:
          if (bit_end) begin
            cnt         <= '0;
            state       <= S_DATA;
            o_Tx_Serial <= sh[0];
          end else cnt <= cnt + 1'b1;
        S_DATA:
          if (bit_end) begin
            cnt <= '0;
            if (idx == 4'(DATA_BITS - 1)) begin
              idx         <= '0;
              state       <= (PARITY != 0) ? S_PARITY : S_STOP;
              o_Tx_Serial <= (PARITY != 0) ? par : 1'b1;
            end else begin
              idx         <= idx + 1'b1;
              sh          <= sh >> 1;
              o_Tx_Serial <= sh[1];
            end
          end else cnt <= cnt + 1'b1;
        S_PARITY:
          if (bit_end) begin
            cnt         <= '0;
            state       <= S_STOP;
            o_Tx_Serial <= 1'b1;
          end else cnt <= cnt + 1'b1;
        S_STOP:
          if (bit_end) begin
            cnt <= '0;
            if (last_stop) begin
              idx       <= '0;
              o_Tx_Done <= 1'b1;
              // a queued byte starts on the next edge with no idle gap
              if (start) begin
                sh          <= start_byte;
                par         <= (PARITY == 1) ? ~^start_byte : ^start_byte;
                state       <= S_START;
                o_Tx_Serial <= 1'b0;
              end else begin
                state       <= S_IDLE;
                o_Tx_Active <= 1'b0;
              end
            end else idx <= idx + 1'b1;
          end else cnt <= cnt + 1'b1;
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          idx         <= '0;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked against a frame-level bit model
module tb_uart_tx_param;
  localparam int CPB [4] = '{4, 4, 4, 1};
  localparam int DB  [4] = '{8, 8, 8, 7};
  localparam int PAR [4] = '{2, 1, 0, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};
  logic clk;
  logic rst_n;
  logic dv [4];
  logic [8:0] tx_byte [4];
  logic ready [4];
  logic active [4];
  logic serial [4];
  logic done [4];
  int checks = 0;
  int errors = 0;
  typedef struct {
    int k;
    logic [8:0] data;
    logic [15:0] frame;
    int n;
  } vec_t;
  vec_t vecs [4];
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_param #(
      .CLKS_PER_BIT(CPB[g]),
      .DATA_BITS(DB[g]),
      .PARITY(PAR[g]),
      .STOP_BITS(SB[g]),
      .FIFO_DEPTH(4)
    ) u_dut (
      .i_Clock(clk),
      .i_Rst_L(rst_n),
      .i_Tx_DV(dv[g]),
      .i_Tx_Byte(tx_byte[g][DB[g]-1:0]),
      .o_Tx_Ready(ready[g]),
      .o_Tx_Active(active[g]),
      .o_Tx_Serial(serial[g]),
      .o_Tx_Done(done[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // line bits of one frame in transmit order, built from the frame format rules
  function automatic void model(input int k, input logic [8:0] d, output logic [15:0] fr, output int n);
    int ones;
    ones = 0;
    fr = '0;
    n = 1;
    for (int i = 0; i < DB[k]; i++) begin
      fr[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (PAR[k] != 0) begin
      fr[n] = (PAR[k] == 2) ? ones[0] : ~ones[0];
      n++;
    end
    for (int i = 0; i < SB[k]; i++) begin
      fr[n] = 1'b1;
      n++;
    end
  endfunction
  task automatic send(input int k, input logic [8:0] d, input logic [15:0] fr, input int n, input int inj);
    int c;
    c = CPB[k];
    @(negedge clk);
    chk("ready_idle", ready[k], 1);
    dv[k] = 1'b1;
    tx_byte[k] = d;
    @(posedge clk);
    #1 dv[k] = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
    chk("fifo_latency_line", serial[k], 1);
    chk("fifo_latency_active", active[k], 0);
`endif
    for (int j = 0; j < n * c; j++) begin
      @(negedge clk);
      chk("line", serial[k], fr[j / c]);
      chk("active", active[k], 1);
      chk("done_mid", done[k], 0);
`ifndef UART_TX_FIFO_EN
      chk("ready_busy", ready[k], 0);
`endif
      dv[k] = (j == inj);
      if (j == inj) tx_byte[k] = 9'h03C;
    end
    @(negedge clk);
    dv[k] = 1'b0;
    chk("done_pulse", done[k], 1);
    chk("active_end", active[k], 0);
    chk("line_end", serial[k], 1);
    @(negedge clk);
    chk("done_single", done[k], 0);
  endtask
  initial begin
    logic [15:0] fr;
    int n;
    logic [8:0] d;
    vecs[0] = '{0, 9'h0A5, 16'h054A, 11};
    vecs[1] = '{1, 9'h0A5, 16'h074A, 11};
    vecs[2] = '{2, 9'h0A5, 16'h034A, 10};
    vecs[3] = '{3, 9'h041, 16'h0382, 10};
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      tx_byte[k] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_line", serial[k], 1);
      chk("rst_active", active[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_ready", ready[k], 1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
`ifdef UART_TX_FIFO_EN
      send(vecs[i].k, vecs[i].data, vecs[i].frame, vecs[i].n, -1);
`else
      send(vecs[i].k, vecs[i].data, vecs[i].frame, vecs[i].n, (vecs[i].k == 0) ? 20 : -1);
`endif
    end
    for (int r = 0; r < 16; r++) begin
      int k;
      k = r % 4;
      d = 9'($urandom_range(0, (1 << DB[k]) - 1));
      model(k, d, fr, n);
      send(k, d, fr, n, -1);
    end
`ifdef UART_TX_FIFO_EN
    begin
      logic [15:0] frs [3];
      int f;
      model(0, 9'h011, frs[0], n);
      model(0, 9'h022, frs[1], n);
      model(0, 9'h033, frs[2], n);
      f = n * CPB[0];
      @(negedge clk);
      dv[0] = 1'b1;
      tx_byte[0] = 9'h011;
      @(negedge clk);
      chk("fifo_ready_1", ready[0], 1);
      tx_byte[0] = 9'h022;
      for (int j = 0; j < 3 * f; j++) begin
        @(negedge clk);
        if (j == 0) chk("fifo_ready_2", ready[0], 1);
        dv[0] = (j == 0);
        tx_byte[0] = 9'h033;
        chk("fifo_line", serial[0], frs[j / f][(j % f) / CPB[0]]);
        chk("fifo_active", active[0], 1);
        chk("fifo_ready", ready[0], 1);
        chk("fifo_done", done[0], (j > 0 && j % f == 0) ? 1 : 0);
      end
      @(negedge clk);
      chk("fifo_done_last", done[0], 1);
      chk("fifo_active_end", active[0], 0);
      chk("fifo_line_end", serial[0], 1);
      @(negedge clk);
    end
`endif
    @(negedge clk);
    dv[0] = 1'b1;
    tx_byte[0] = 9'h0A5;
    @(posedge clk);
    #1 dv[0] = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(posedge clk);
`endif
    repeat (17) @(posedge clk);
    #2;
    chk("pre_abort_line", serial[0], 0);
    rst_n = 1'b0;
    #1;
    chk("abort_line", serial[0], 1);
    chk("abort_active", active[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_ready", ready[0], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post_abort_done", done[0], 0);
      chk("post_abort_line", serial[0], 1);
    end
    send(vecs[0].k, vecs[0].data, vecs[0].frame, vecs[0].n, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
